// File: rtl/disparity_search_ctrl.sv
// Disparity search controller. One pixel job compares the left census code
// against MAX_DISP right candidates through a shared hamming_distance unit and
// keeps the lowest-cost disparity; ties go to the lowest disparity.
// Optional feature macro: COST_THRESH_CHECK_EN flags a result whose best cost
// exceeds COST_THRESH.
module disparity_search_ctrl #(
  parameter int CENSUS_WIDTH = 8,
  parameter int MAX_DISP     = 16,
  parameter int COST_THRESH  = 2,
  localparam int DW = $clog2(MAX_DISP),
  localparam int CW = $clog2(CENSUS_WIDTH + 1)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             pix_valid,
  output logic                             pix_ready,
  input  logic [CENSUS_WIDTH-1:0]          census_left,
  input  logic [MAX_DISP*CENSUS_WIDTH-1:0] right_window,
  output logic [CENSUS_WIDTH-1:0]          hd_census_left,
  output logic [CENSUS_WIDTH-1:0]          hd_census_right,
  output logic                             hd_valid_in,
  input  logic [CW-1:0]                    hd_dist,
  input  logic                             hd_valid_out,
  output logic                             res_valid,
  input  logic                             res_ready,
  output logic [DW-1:0]                    res_disp,
  output logic [CW-1:0]                    res_cost,
  output logic                             res_invalid,
  output logic                             busy
);

  if (MAX_DISP < 2 || COST_THRESH < 0) begin : g_param_err
    $error("disparity_search_ctrl: MAX_DISP must be >= 2 and COST_THRESH non-negative");
  end

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StOut} state_e;

  // Result counter is one bit wider so a count of MAX_DISP never wraps.
  localparam logic [DW:0]   NumDisp  = (DW + 1)'(MAX_DISP);
  localparam logic [DW-1:0] LastDisp = DW'(MAX_DISP - 1);

  state_e                  state_q, state_d;
  logic                    ready_en_q;
  logic [CENSUS_WIDTH-1:0] left_q;
  logic [CENSUS_WIDTH-1:0] win_q [MAX_DISP];
  logic [DW-1:0]           iss_cnt_q, iss_cnt_d;
  logic [DW:0]             res_cnt_q, res_cnt_d;
  logic [CW-1:0]           best_cost_q, best_cost_d;
  logic [DW-1:0]           best_disp_q, best_disp_d;
  logic                    load;
  logic                    capture;

  // State, counters and best-so-far registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ready_en_q  <= 1'b0;
      iss_cnt_q   <= '0;
      res_cnt_q   <= '0;
      best_cost_q <= '0;
      best_disp_q <= '0;
    end else begin
      state_q     <= state_d;
      ready_en_q  <= 1'b1;
      iss_cnt_q   <= iss_cnt_d;
      res_cnt_q   <= res_cnt_d;
      best_cost_q <= best_cost_d;
      best_disp_q <= best_disp_d;
    end
  end

  // Job operands, captured on acceptance and held for the whole search.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      left_q <= '0;
      for (int d = 0; d < MAX_DISP; d++) win_q[d] <= '0;
    end else if (load) begin
      left_q <= census_left;
      for (int d = 0; d < MAX_DISP; d++) begin
        win_q[d] <= right_window[d*CENSUS_WIDTH +: CENSUS_WIDTH];
      end
    end
  end

  // Next-state, result tracking and handshake outputs.
  always_comb begin
    state_d     = state_q;
    iss_cnt_d   = iss_cnt_q;
    res_cnt_d   = res_cnt_q;
    best_cost_d = best_cost_q;
    best_disp_d = best_disp_q;
    load        = 1'b0;
    pix_ready   = 1'b0;
    hd_valid_in = 1'b0;
    res_valid   = 1'b0;

    // Results arrive in order; the k-th one of a job belongs to disparity k.
    capture = ((state_q == StIssue) || (state_q == StDrain)) && hd_valid_out &&
              (res_cnt_q != NumDisp);
    if (capture) begin
      if ((res_cnt_q == '0) || (hd_dist < best_cost_q)) begin
        best_cost_d = hd_dist;
        best_disp_d = res_cnt_q[DW-1:0];
      end
      res_cnt_d = res_cnt_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        pix_ready = ready_en_q;
        if (pix_valid && ready_en_q) begin
          load        = 1'b1;
          iss_cnt_d   = '0;
          res_cnt_d   = '0;
          best_cost_d = '0;
          best_disp_d = '0;
          state_d     = StIssue;
        end
      end
      StIssue: begin
        hd_valid_in = 1'b1;
        if (iss_cnt_q == LastDisp) begin
          state_d = (res_cnt_d == NumDisp) ? StOut : StDrain;
        end else begin
          iss_cnt_d = iss_cnt_q + 1'b1;
        end
      end
      StDrain: begin
        if (res_cnt_d == NumDisp) state_d = StOut;
      end
      StOut: begin
        res_valid = 1'b1;
        if (res_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign hd_census_left  = left_q;
  assign hd_census_right = win_q[iss_cnt_q];
  assign res_disp        = res_valid ? best_disp_q : '0;
  assign res_cost        = res_valid ? best_cost_q : '0;
  assign busy            = (state_q != StIdle);

`ifdef COST_THRESH_CHECK_EN
  assign res_invalid = res_valid && (32'(best_cost_q) > 32'(COST_THRESH));
`else
  assign res_invalid = 1'b0;
`endif

endmodule

// File: doc/disparity_search_ctrl.md
DISPARITY_SEARCH_CTRL -- requirements
Module: disparity_search_ctrl

Interface
REQ-001 SHALL have parameter CENSUS_WIDTH, default 8: census code width in bits.
REQ-002 SHALL have parameter MAX_DISP, default 16: disparities searched per pixel (≥2).
REQ-003 SHALL have parameter COST_THRESH, default 2: maximum acceptable best cost (used only under REQ-026).
REQ-004 SHALL derive DW = clog2(MAX_DISP) and CW = clog2(CENSUS_WIDTH+1).
REQ-005 SHALL have ports:
 clk  in  1  single clock, rising edge;
 rst_n  in  1  reset, asynchronous, active-low;
 pix_valid  in  1  pixel job offered;
 pix_ready  out  1  job accepted when pix_valid && pix_ready;
 census_left  in  CENSUS_WIDTH  left census code of pixel;
 right_window  in  MAX_DISP*CENSUS_WIDTH  right census codes, slice d = disparity d;
 hd_census_left  out  CENSUS_WIDTH  to shared hamming_distance unit;
 hd_census_right  out  CENSUS_WIDTH  to shared hamming_distance unit;
 hd_valid_in  out  1  issue strobe to unit;
 hd_dist  in  CW  distance from unit;
 hd_valid_out  in  1  distance valid from unit;
 res_valid  out  1  result available;
 res_ready  in  1  result consumed when res_valid && res_ready;
 res_disp  out  DW  winning disparity;
 res_cost  out  CW  winning cost;
 res_invalid  out  1  best cost exceeds threshold;
 busy  out  1  job in progress (state != IDLE).

Function
REQ-006 SHALL implement FSM states IDLE, ISSUE, DRAIN, OUT.
REQ-007 SHALL assert pix_ready only in IDLE; on acceptance, register census_left and right_window, then enter ISSUE.
REQ-008 In ISSUE, SHALL assert hd_valid_in for exactly MAX_DISP consecutive cycles, issuing d = 0..MAX_DISP-1 in order, with hd_census_right = registered slice d and hd_census_left = registered left code.
REQ-009 SHALL go from ISSUE to DRAIN after issuing d = MAX_DISP-1, or to OUT directly if all MAX_DISP results have already been captured.
REQ-010 SHALL not depend on a fixed unit latency; results arrive in order, and the k-th hd_valid_out of a job belongs to disparity k (result counter).
REQ-011 SHALL load the first result of a job unconditionally as the best (cost, disparity).
REQ-012 SHALL replace the best only when hd_dist < best cost (strict), so ties resolve to the lowest disparity.
REQ-013 SHALL leave DRAIN for OUT the cycle after the MAX_DISP-th result is captured; res_valid rises in that first OUT cycle.
REQ-014 SHALL hold res_valid, res_disp, res_cost and res_invalid stable in OUT until res_ready; on the handshake, return to IDLE (pix_ready high the next cycle).
REQ-015 SHALL ignore hd_valid_out while in IDLE or OUT.
REQ-016 SHALL deassert hd_valid_in in every state except ISSUE.
REQ-017 The result counter SHALL be DW+1 bits wide, so the count reaching MAX_DISP does not wrap when MAX_DISP is a power of two.
REQ-018 res_disp and res_cost SHALL be zero whenever res_valid is low.

Reset
REQ-019 While rst_n is low, SHALL force state IDLE immediately and asynchronously.
REQ-020 Reset values SHALL be: pix_ready 0, hd_valid_in 0, res_valid 0, res_disp 0, res_cost 0, res_invalid 0, busy 0, and all counters and best registers 0. pix_ready rises on the first clock edge after release.
REQ-021 Reset asserted mid-job SHALL discard the job; results returned after release belong to no job and SHALL be ignored per REQ-015.

Configuration
REQ-022 Macro COST_THRESH_CHECK_EN SHALL select the threshold check.
REQ-023 With the macro defined, res_invalid SHALL equal (res_cost > COST_THRESH) during OUT; res_disp and res_cost are still reported.
REQ-024 Without the macro, res_invalid SHALL be constant 0, with no comparator logic.
REQ-025 The port list SHALL be identical in both builds.
REQ-026 The COST_THRESH parameter SHALL have effect only when COST_THRESH_CHECK_EN is defined.

Verification
Bench setup: CENSUS_WIDTH=8, MAX_DISP=4, real hamming_distance unit, 50 MHz clock.
REQ-027 Scenario: left=0x55, window d0..d3={0xAA,0x54,0x55,0x00}, costs 8,1,0,4 -> res_disp=2, res_cost=0, res_invalid=0.
REQ-028 Scenario: left=0xF0, window={0x0F,0xF1,0xFF,0xF2}, costs 8,1,4,1 (tie d1/d3) -> res_disp=1, res_cost=1.
REQ-029 Scenario: res_ready held low 5 cycles after res_valid -> outputs stable, pix_ready=0, hd_valid_in=0 throughout; accept -> pix_ready=1 next cycle.
REQ-030 Scenario: rst_n pulsed low during 2nd ISSUE cycle -> all outputs 0 immediately; late hd_valid_out ignored; next job left=0x55, window of REQ-027 -> res_disp=2.
REQ-031 Scenario (macro defined, COST_THRESH=2): left=0x00, window={0x07,0x0F,0xFF,0x3F}, costs 3,4,8,6 -> res_disp=0, res_cost=3, res_invalid=1; same stimulus without macro -> res_invalid=0.
REQ-032 Scenario: hd_valid_in SHALL assert for exactly 4 cycles per job, and the hd_census_right sequence SHALL equal slices d0..d3.
